// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, FSM state type, S-box and Rcon lookups.
package aes_pkg;

    localparam int KEY_W  = 128;
    localparam int NUM_RK = 11;

    localparam logic [3:0] LAST_RK   = 4'(NUM_RK - 1);
    localparam logic [3:0] LAST_STEP = 4'(NUM_RK - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] step);
        logic [7:0] r;
        case (step)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_expansion_ctrl_round_key.sv
// One AES-128 key-schedule step: derives round key count+1 from round key count.
module roundKey
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] inputKey,
    input  logic [3:0]       count,
    output logic [KEY_W-1:0] outputRoundKey
);

    logic [31:0] w0_s, w1_s, w2_s, w3_s;
    logic [31:0] temp_s;
    logic [31:0] n0_s, n1_s, n2_s, n3_s;

    // RotWord, SubWord and Rcon on the last word, then the word-wise XOR chain.
    always_comb begin
        w0_s   = inputKey[127:96];
        w1_s   = inputKey[95:64];
        w2_s   = inputKey[63:32];
        w3_s   = inputKey[31:0];
        temp_s = sub_word({w3_s[23:0], w3_s[31:24]}) ^ {rcon(count), 24'h000000};
        n0_s   = w0_s ^ temp_s;
        n1_s   = w1_s ^ n0_s;
        n2_s   = w2_s ^ n1_s;
        n3_s   = w3_s ^ n2_s;
        outputRoundKey = {n0_s, n1_s, n2_s, n3_s};
    end

endmodule

// File: rtl/key_expansion_ctrl.sv
// Sequential AES-128 key expansion: one schedule step per clock into an 11-entry
// round-key bank, served through a registered random-access read port.
module key_expansion_ctrl #(
    parameter int KEY_W      = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             done,
    input  logic [3:0]       rd_addr,
    output logic [KEY_W-1:0] rd_key
);

    import aes_pkg::*;

    ks_state_t        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [KEY_W-1:0] rd_key_q, rd_key_d;
    logic [KEY_W-1:0] bank_q [0:NUM_ROUNDS];
    logic [KEY_W-1:0] bank_d [0:NUM_ROUNDS];
    logic [KEY_W-1:0] step_key_s;

    roundKey u_round_key (
        .inputKey       (bank_q[cnt_q]),
        .count          (cnt_q),
        .outputRoundKey (step_key_s)
    );

    // Next-state, counter, status and bank-write logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        bank_d  = bank_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    bank_d[0] = key_in;
                    cnt_d     = 4'd0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    state_d   = EXPAND;
                end else begin
                    state_d = state_q;
                end
            end
            EXPAND: begin
                bank_d[cnt_q + 4'd1] = step_key_s;
                if (cnt_q == LAST_STEP) begin
                    cnt_d   = 4'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Read mux; the bank is read before this edge's write, so same-cycle reads see old data.
    always_comb begin
        if (rd_addr <= LAST_RK) begin
            rd_key_d = bank_q[rd_addr];
        end else begin
            rd_key_d = '0;
        end
    end

    // State, counter, bank and read-port registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_key_q <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_key_q <= rd_key_d;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign rd_key = rd_key_q;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Directed self-checking bench for key_expansion_ctrl using FIPS-197 key schedules.
module tb_key_expansion_ctrl;

    localparam logic [127:0] KA   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KA1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KA10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KB   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KB10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         n_rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy;
    logic         done;
    logic [3:0]   rd_addr = 4'd0;
    logic [127:0] rd_key;

    int pass_cnt = 0;
    int total_cnt = 0;

    key_expansion_ctrl dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .start   (start),
        .key_in  (key_in),
        .busy    (busy),
        .done    (done),
        .rd_addr (rd_addr),
        .rd_key  (rd_key)
    );

    always #5 clk = ~clk;

    // Returns at the falling edge after E0 (the edge that sampled start).
    task automatic pulse_start(input logic [127:0] k);
        @(negedge clk);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic read_entry(input logic [3:0] a, output logic [127:0] v);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        v = rd_key;
    endtask

    task automatic test_reset;
        logic [127:0] v;
        #1 n_rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
        total_cnt++; if (rd_key !== 128'd0) $display("FAIL reset_rd_key: got %h expected 0", rd_key); else pass_cnt++;
        n_rst = 1'b1;
        read_entry(4'd10, v);
        total_cnt++; if (v !== 128'd0) $display("FAIL reset_entry10: got %h expected 0", v); else pass_cnt++;
    endtask

    task automatic test_expand_fips;
        logic [127:0] v;
        pulse_start(KA);
        total_cnt++; if (busy !== 1'b1) $display("FAIL fips_busy_e0: got %b expected 1", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL fips_done_e0: got %b expected 0", done); else pass_cnt++;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 9) begin
                total_cnt++; if (done !== 1'b0) $display("FAIL fips_done_e9: got %b expected 0", done); else pass_cnt++;
                total_cnt++; if (busy !== 1'b1) $display("FAIL fips_busy_e9: got %b expected 1", busy); else pass_cnt++;
            end
            if (i == 10) begin
                total_cnt++; if (done !== 1'b1) $display("FAIL fips_done_e10: got %b expected 1", done); else pass_cnt++;
                total_cnt++; if (busy !== 1'b0) $display("FAIL fips_busy_e10: got %b expected 0", busy); else pass_cnt++;
            end
        end
        read_entry(4'd0, v);
        total_cnt++; if (v !== KA) $display("FAIL fips_entry0: got %h expected %h", v, KA); else pass_cnt++;
        read_entry(4'd1, v);
        total_cnt++; if (v !== KA1) $display("FAIL fips_entry1: got %h expected %h", v, KA1); else pass_cnt++;
        read_entry(4'd10, v);
        total_cnt++; if (v !== KA10) $display("FAIL fips_entry10: got %h expected %h", v, KA10); else pass_cnt++;
    endtask

    task automatic test_start_ignored;
        logic [127:0] v;
        pulse_start(KA);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start  = (i == 3);
            key_in = (i == 3) ? KB : KA;
            if (i == 9) begin
                total_cnt++; if (done !== 1'b0) $display("FAIL ign_done_e9: got %b expected 0", done); else pass_cnt++;
            end
            if (i == 10) begin
                total_cnt++; if (done !== 1'b1) $display("FAIL ign_done_e10: got %b expected 1", done); else pass_cnt++;
            end
        end
        start = 1'b0;
        read_entry(4'd0, v);
        total_cnt++; if (v !== KA) $display("FAIL ign_entry0: got %h expected %h", v, KA); else pass_cnt++;
        read_entry(4'd10, v);
        total_cnt++; if (v !== KA10) $display("FAIL ign_entry10: got %h expected %h", v, KA10); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic [127:0] v;
        @(negedge clk);
        rd_addr = 4'd0;
        pulse_start(KB);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
        end
        n_rst = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL mid_rst_done: got %b expected 0", done); else pass_cnt++;
        total_cnt++; if (rd_key !== 128'd0) $display("FAIL mid_rst_rd_key: got %h expected 0", rd_key); else pass_cnt++;
        @(negedge clk);
        n_rst = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            read_entry(4'(k), v);
            total_cnt++; if (v !== 128'd0) $display("FAIL mid_rst_entry%0d: got %h expected 0", k, v); else pass_cnt++;
        end
        pulse_start(KA);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 10) begin
                total_cnt++; if (done !== 1'b1) $display("FAIL mid_rst_redo_done: got %b expected 1", done); else pass_cnt++;
            end
        end
        read_entry(4'd10, v);
        total_cnt++; if (v !== KA10) $display("FAIL mid_rst_redo_entry10: got %h expected %h", v, KA10); else pass_cnt++;
    endtask

    task automatic test_read_port;
        @(negedge clk);
        rd_addr = 4'd1;
        @(negedge clk);
        rd_addr = 4'd0;
        @(negedge clk);
        total_cnt++; if (rd_key !== KA) $display("FAIL rd_addr0: got %h expected %h", rd_key, KA); else pass_cnt++;
        rd_addr = 4'd10;
        @(negedge clk);
        total_cnt++; if (rd_key !== KA10) $display("FAIL rd_addr10: got %h expected %h", rd_key, KA10); else pass_cnt++;
        rd_addr = 4'd11;
        @(negedge clk);
        total_cnt++; if (rd_key !== 128'd0) $display("FAIL rd_addr11: got %h expected 0", rd_key); else pass_cnt++;
        rd_addr = 4'd15;
        @(negedge clk);
        total_cnt++; if (rd_key !== 128'd0) $display("FAIL rd_addr15: got %h expected 0", rd_key); else pass_cnt++;
    endtask

    task automatic test_restart;
        logic [127:0] v;
        @(negedge clk);
        rd_addr = 4'd10;
        pulse_start(KB);
        total_cnt++; if (done !== 1'b0) $display("FAIL restart_done_e0: got %b expected 0", done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL restart_busy_e0: got %b expected 1", busy); else pass_cnt++;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 10) begin
                total_cnt++; if (done !== 1'b1) $display("FAIL restart_done_e10: got %b expected 1", done); else pass_cnt++;
                total_cnt++; if (rd_key !== KA10) $display("FAIL restart_same_cycle_read: got %h expected %h", rd_key, KA10); else pass_cnt++;
            end
        end
        @(negedge clk);
        total_cnt++; if (rd_key !== KB10) $display("FAIL restart_entry10: got %h expected %h", rd_key, KB10); else pass_cnt++;
        read_entry(4'd0, v);
        total_cnt++; if (v !== KB) $display("FAIL restart_entry0: got %h expected %h", v, KB); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_expand_fips();
        test_start_ignored();
        test_reset_mid();
        test_read_port();
        test_restart();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/key_expansion_ctrl.md
# key_expansion_ctrl

Sequential AES-128 key-expansion controller. It replaces the fully unrolled ten-stage key schedule with a single round-key step iterated once per clock. Expanded keys are stored in an 11-entry register bank and served to the cipher and inverse-cipher round engines through a registered random-access read port. It sits between the key-load interface and the encrypt/decrypt round controllers.

## Interface
- `KEY_W`, 128, key and round-key width; only 128 is supported.
- `NUM_ROUNDS`, 10, number of expansion steps; only 10 is supported. The bank holds `NUM_ROUNDS+1` entries.

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to expand `key_in`.
- `key_in`  in  `KEY_W`  cipher key; sampled only on an accepted `start`.
- `busy`  out  1  high while expansion is in progress.
- `done`  out  1  high once all 11 round keys are valid; stays high until the next accepted `start` or reset.
- `rd_addr`  in  4  round-key index, 0 to 10.
- `rd_key`  out  `KEY_W`  registered round key for `rd_addr`.

## Operation
- FSM states: `IDLE`, `EXPAND`, `DONE`. The state is `IDLE` at reset.
- `IDLE` or `DONE` with `start=1` (accepted start):
  - write `bank[0] <= key_in`;
  - set `cnt <= 0`, `done <= 0`, `busy <= 1`;
  - go to `EXPAND`.
- `EXPAND`, every cycle:
  - write `bank[cnt+1] <= step(bank[cnt], cnt)`, then `cnt <= cnt+1`;
  - when `cnt==9`, write entry 10, then `busy <= 0`, `done <= 1`, and go to `DONE`.
- `start` during `EXPAND` is ignored. There is no abort and no queuing.
- `step` applies RotWord, SubWord, the Rcon selected by `cnt` (0x01, 0x02, …, 0x1b, 0x36), and the word-wise XOR chain.
- Read port: `rd_key <= bank[rd_addr]` every cycle, in any state.
  - `rd_addr` from 11 to 15 returns all zeros.
  - During `EXPAND`, reading an entry that has not yet been written returns its previous contents. Consumers must gate reads with `done`.
- A new `start` in `DONE` overwrites entries incrementally. Old keys are not valid once `done` falls.
- `cnt` is 4 bits and never exceeds 9 in `EXPAND`. It must not wrap.

## Timing
- Reset (`n_rst=0`, asynchronous):
  - `busy=0`, `done=0`, `rd_key=0`;
  - every bank entry = 0, `cnt=0`, state `IDLE`;
  - this takes effect immediately, including mid-expansion. No partial results survive.
- `start` is sampled at edge E0. Entry 0 is written at E0. Entries 1 to 10 are written at E1 to E10.
- `busy` is high after E0 through E10. It is low after E10.
- `done` is high after E10. That is 11 edges after start is sampled, and 10 cycles of expansion.
- Read latency: one cycle. `rd_addr` sampled at edge N appears on `rd_key` after edge N.
- A read of entry k in the same cycle that entry k is written returns the old value. The new value is visible one cycle later.
- `start` in the same cycle as reset deassertion is ignored if `n_rst` is still low at that edge.

## Structure
- Shared package `aes_pkg`:
  - constants `KEY_W=128`, `NUM_RK=11`;
  - the Rcon table;
  - the state typedef `ks_state_t` (`IDLE`, `EXPAND`, `DONE`).
- One combinational sub-module: the existing `roundKey` step (ports `inputKey`, 4-bit `count`, `outputRoundKey`), instantiated once and fed from `bank[cnt]`.
- This block contains only the FSM, the counter, the register bank, and the read mux.

## Test plan
- Key `2b7e151628aed2a6abf7158809cf4f3c`, pulse `start`:
  - `done` rises 11 edges later and `busy` falls together with it;
  - entry 1 = `a0fafe1788542cb123a339392a6c7605`;
  - entry 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6`.
- Key `000102030405060708090a0b0c0d0e0f`:
  - entry 0 = the key;
  - entry 10 = `13111d7fe3944a17f307a78b4d2b30c5`.
- Pulse `start` again at cycle 4 of `EXPAND` with a different key:
  - the pulse is ignored;
  - the results match the first key;
  - `done` timing is unchanged.
- Drop `n_rst` at cycle 6 of expansion:
  - immediately `busy=0`, `done=0`, and `rd_key=0`;
  - after release, reads of entries 0 to 10 all return 0;
  - a fresh `start` completes normally.
- Read `rd_addr` values 0, 10, 11, and 15 back-to-back in `DONE`:
  - one-cycle latency on each read;
  - addresses 11 and 15 return 0.
- After `DONE`, `start` with a new key:
  - `done` drops after E0;
  - the new entry 10 is correct after E10.
